// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizing for the writeback arbiter and its picker.
package C;
    localparam int NR_FU       = 4;
    localparam int NR_WB_PORTS = 2;
    localparam int PC_W        = 32;
    localparam int ID_W        = 4;
    localparam int PRD_W       = 6;
    localparam int XLEN        = 32;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [ID_W-1:0]  id;
        logic [PRD_W-1:0] prd;
        logic [XLEN-1:0]  rdval;
    } fu_output_t;

    typedef logic [NR_WB_PORTS-1:0] wb_bitvector_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/wb_rr_picker.sv
// Rotating first-P picker: grants up to P requesters scanning from start_i upward (mod N).
module wb_rr_picker
    import C::*;
#(
    parameter int N  = C::NR_FU,
    parameter int P  = C::NR_WB_PORTS,
    parameter int PW = C::ptr_width(N),
    parameter int CW = C::ptr_width(P)
) (
    input  logic [N-1:0]        req_i,
    input  logic [PW-1:0]       start_i,
    output logic [P-1:0][N-1:0] grant_o,
    output logic [P-1:0]        grant_valid_o,
    output logic [PW-1:0]       last_o,
    output logic                any_o
);
    always_comb begin
        int cnt;
        int idx;
        logic [PW-1:0] idx_s;
        grant_o       = '0;
        grant_valid_o = '0;
        last_o        = '0;
        cnt           = 0;
        idx           = 0;
        idx_s         = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(start_i) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_s = PW'(idx);
            if (req_i[idx_s] && (cnt < P)) begin
                grant_o[CW'(cnt)][idx_s]  = 1'b1;
                grant_valid_o[CW'(cnt)]   = 1'b1;
                last_o                    = idx_s;
                cnt                       = cnt + 1;
            end
        end
        any_o = grant_valid_o[0];
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-FU holding registers, round-robin grant onto NR_WB_PORTS ports,
// same-cycle bypass plus registered writeback. Define WB_ARBITER_STATS_EN for the conflict counter.
module wb_arbiter
    import C::*;
#(
    parameter int NR_FU       = C::NR_FU,
    parameter int NR_WB_PORTS = C::NR_WB_PORTS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  fu_output_t [NR_FU-1:0]            fu_out_i,
    input  logic [NR_FU-1:0]                  fu_out_valid_i,
    output logic [NR_FU-1:0]                  fu_out_ready_o,
    input  logic                              flush_i,
    output fu_output_t [NR_WB_PORTS-1:0]      bypass_o,
    output wb_bitvector_t                     bypass_valid_o,
    output fu_output_t [NR_WB_PORTS-1:0]      wb_o,
    output wb_bitvector_t                     wb_valid_o,
    output logic [31:0]                       stat_conflict_o
);
    localparam int PW = C::ptr_width(NR_FU);

    logic [NR_FU-1:0]                  hold_valid_q, hold_valid_d;
    fu_output_t [NR_FU-1:0]            hold_data_q, hold_data_d;
    logic [PW-1:0]                     rr_ptr_q, rr_ptr_d;
    wb_bitvector_t                     wb_valid_q, wb_valid_d;
    fu_output_t [NR_WB_PORTS-1:0]      wb_q, wb_d;

    logic [NR_FU-1:0]                  cand;
    logic [NR_FU-1:0]                  granted_fu;
    logic [NR_FU-1:0]                  transfer;
    logic [NR_WB_PORTS-1:0][NR_FU-1:0] grant;
    wb_bitvector_t                     grant_valid;
    logic [PW-1:0]                     last_idx;
    logic                              any_grant;
    logic                              prd_clash;

    // Only registered entries compete; flush and reset suppress every grant.
    assign cand = (rst || flush_i) ? '0 : hold_valid_q;

    wb_rr_picker #(
        .N (NR_FU),
        .P (NR_WB_PORTS),
        .PW(PW)
    ) u_picker (
        .req_i        (cand),
        .start_i      (rr_ptr_q),
        .grant_o      (grant),
        .grant_valid_o(grant_valid),
        .last_o       (last_idx),
        .any_o        (any_grant)
    );

    always_comb begin
        granted_fu = '0;
        bypass_o   = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            granted_fu = granted_fu | grant[p];
            for (int f = 0; f < NR_FU; f++) begin
                if (grant[p][f]) begin
                    bypass_o[p] = hold_data_q[f];
                end
            end
        end
    end

    assign bypass_valid_o = grant_valid;

    generate
        for (genvar gi = 0; gi < NR_FU; gi++) begin : g_fu
            assign fu_out_ready_o[gi] = ~rst & ~flush_i & (~hold_valid_q[gi] | granted_fu[gi]);
            assign transfer[gi]       = fu_out_valid_i[gi] & fu_out_ready_o[gi];
            assign hold_valid_d[gi]   = flush_i ? 1'b0
                                                : (transfer[gi] | (hold_valid_q[gi] & ~granted_fu[gi]));
            assign hold_data_d[gi]    = transfer[gi] ? fu_out_i[gi] : hold_data_q[gi];
        end
    endgenerate

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            rr_ptr_d = (last_idx == PW'(NR_FU - 1)) ? '0 : last_idx + 1'b1;
        end
        wb_d       = bypass_o;
        wb_valid_d = bypass_valid_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= '0;
            rr_ptr_q     <= '0;
            wb_valid_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            wb_valid_q   <= wb_valid_d;
        end
    end

    // Data paths carry no reset; their valids qualify them.
    always_ff @(posedge clk) begin
        hold_data_q <= hold_data_d;
        wb_q        <= wb_d;
    end

    assign wb_o       = wb_q;
    assign wb_valid_o = wb_valid_q;

    // Two ports writing the same physical register in one cycle is an upstream bug.
    always_comb begin
        prd_clash = 1'b0;
        for (int a = 0; a < NR_WB_PORTS; a++) begin
            for (int b = a + 1; b < NR_WB_PORTS; b++) begin
                if (grant_valid[a] && grant_valid[b] && (bypass_o[a].prd == bypass_o[b].prd)) begin
                    prd_clash = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!prd_clash);
        end
    end

`ifdef WB_ARBITER_STATS_EN
    logic [31:0] stat_q, stat_d;
    logic        conflict;

    assign conflict = ~rst & ~flush_i & (|(hold_valid_q & ~granted_fu));
    assign stat_d   = (conflict && (stat_q != '1)) ? stat_q + 32'd1 : stat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_conflict_o = stat_q;
`else
    assign stat_conflict_o = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (NR_FU=4, NR_WB_PORTS=2); honours WB_ARBITER_STATS_EN for counter checks.
module tb_wb_arbiter;
    import C::*;

    logic                 clk = 1'b0;
    logic                 rst;
    fu_output_t [3:0]     fu_out_i;
    logic [3:0]           fu_out_valid_i;
    logic [3:0]           fu_out_ready_o;
    logic                 flush_i;
    fu_output_t [1:0]     bypass_o;
    wb_bitvector_t        bypass_valid_o;
    fu_output_t [1:0]     wb_o;
    wb_bitvector_t        wb_valid_o;
    logic [31:0]          stat_conflict_o;

    int total  = 0;
    int passed = 0;

    wb_arbiter #(
        .NR_FU      (4),
        .NR_WB_PORTS(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fu_out_i       (fu_out_i),
        .fu_out_valid_i (fu_out_valid_i),
        .fu_out_ready_o (fu_out_ready_o),
        .flush_i        (flush_i),
        .bypass_o       (bypass_o),
        .bypass_valid_o (bypass_valid_o),
        .wb_o           (wb_o),
        .wb_valid_o     (wb_valid_o),
        .stat_conflict_o(stat_conflict_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Expected counter value: the count when statistics are built in, otherwise always zero.
    function automatic logic [63:0] es(input int n);
`ifdef WB_ARBITER_STATS_EN
        return 64'(n);
`else
        return 64'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drv(input int f, input logic v, input logic [5:0] prd, input logic [31:0] val);
        fu_out_i[f[1:0]].pc    = 32'h1000 + 32'(f);
        fu_out_i[f[1:0]].id    = 4'(f);
        fu_out_i[f[1:0]].prd   = prd;
        fu_out_i[f[1:0]].rdval = val;
        fu_out_valid_i[f[1:0]] = v;
    endtask

    task automatic idle();
        fu_out_valid_i = '0;
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; fu_out_valid_i = '0; fu_out_i = '0;
        tick(); tick();
        chk("rst_ready", 64'(fu_out_ready_o), 64'h0);
        chk("rst_bypass_valid", 64'(bypass_valid_o), 64'h0);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'h0);
        chk("rst_stat", 64'(stat_conflict_o), 64'h0);
        rst = 1'b0; settle();
        chk("post_rst_ready", 64'(fu_out_ready_o), 64'hF);

        // Single result latency: accept -> bypass +1 -> writeback +2
        drv(0, 1'b1, 6'd5, 32'hAA); settle();
        chk("lat_ready0", 64'(fu_out_ready_o[0]), 64'h1);
        tick(); idle(); settle();
        chk("lat_bp_valid", 64'(bypass_valid_o), 64'h1);
        chk("lat_bp_prd", 64'(bypass_o[0].prd), 64'd5);
        chk("lat_wb_valid_early", 64'(wb_valid_o), 64'h0);
        tick();
        chk("lat_wb_valid", 64'(wb_valid_o), 64'h1);
        chk("lat_wb_prd", 64'(wb_o[0].prd), 64'd5);
        chk("lat_wb_rdval", 64'(wb_o[0].rdval), 64'hAA);
        chk("lat_bp_idle", 64'(bypass_valid_o), 64'h0);

        // Full load from rr_ptr=0: grants alternate {0,1},{2,3}
        rst = 1'b1; tick(); rst = 1'b0;
        for (int f = 0; f < 4; f++) drv(f, 1'b1, 6'(10 + f), 32'h100 + 32'(f));
        settle();
        chk("rr_ready_empty", 64'(fu_out_ready_o), 64'hF);
        tick();
        chk("rr_b_bp_valid", 64'(bypass_valid_o), 64'h3);
        chk("rr_b_bp0", 64'(bypass_o[0].prd), 64'd10);
        chk("rr_b_bp1", 64'(bypass_o[1].prd), 64'd11);
        chk("rr_b_ready", 64'(fu_out_ready_o), 64'h3);
        tick();
        chk("rr_c_bp0", 64'(bypass_o[0].prd), 64'd12);
        chk("rr_c_bp1", 64'(bypass_o[1].prd), 64'd13);
        chk("rr_c_ready", 64'(fu_out_ready_o), 64'hC);
        chk("rr_c_wb_valid", 64'(wb_valid_o), 64'h3);
        chk("rr_c_wb0", 64'(wb_o[0].prd), 64'd10);
        chk("rr_c_wb1", 64'(wb_o[1].prd), 64'd11);
        chk("rr_c_stat", 64'(stat_conflict_o), es(1));
        tick();
        chk("rr_d_bp0", 64'(bypass_o[0].prd), 64'd10);
        chk("rr_d_bp1", 64'(bypass_o[1].prd), 64'd11);
        chk("rr_d_wb0", 64'(wb_o[0].prd), 64'd12);
        chk("rr_d_wb1", 64'(wb_o[1].prd), 64'd13);
        chk("rr_d_stat", 64'(stat_conflict_o), es(2));
        tick(); idle(); settle();
        chk("rr_e_bp0", 64'(bypass_o[0].prd), 64'd12);
        chk("rr_e_bp1", 64'(bypass_o[1].prd), 64'd13);
        tick();
        chk("rr_f_bp_valid", 64'(bypass_valid_o), 64'h3);
        chk("rr_f_bp0", 64'(bypass_o[0].prd), 64'd10);
        chk("rr_f_stat", 64'(stat_conflict_o), es(4));
        tick();
        chk("rr_g_bp_valid", 64'(bypass_valid_o), 64'h0);
        chk("rr_g_stat", 64'(stat_conflict_o), es(4));

        // Backpressure: FU2 full and ungranted, then refilled in its grant cycle
        rst = 1'b1; tick(); rst = 1'b0;
        drv(0, 1'b1, 6'd20, 32'h20); drv(1, 1'b1, 6'd21, 32'h21); drv(2, 1'b1, 6'd22, 32'h22);
        settle(); tick();
        drv(0, 1'b0, 6'd20, 32'h20); drv(1, 1'b0, 6'd21, 32'h21); drv(2, 1'b1, 6'd32, 32'h32);
        settle();
        chk("bp_i_ready", 64'(fu_out_ready_o), 64'hB);
        chk("bp_i_bp0", 64'(bypass_o[0].prd), 64'd20);
        chk("bp_i_bp1", 64'(bypass_o[1].prd), 64'd21);
        tick();
        chk("bp_j_ready", 64'(fu_out_ready_o), 64'hF);
        chk("bp_j_bp_valid", 64'(bypass_valid_o), 64'h1);
        chk("bp_j_bp0", 64'(bypass_o[0].prd), 64'd22);
        chk("bp_j_wb1", 64'(wb_o[1].prd), 64'd21);
        tick(); idle(); settle();
        chk("bp_k_bp_valid", 64'(bypass_valid_o), 64'h1);
        chk("bp_k_bp0", 64'(bypass_o[0].prd), 64'd32);
        chk("bp_k_wb0", 64'(wb_o[0].prd), 64'd22);
        chk("bp_k_stat", 64'(stat_conflict_o), es(1));
        tick();
        chk("bp_l_wb_valid", 64'(wb_valid_o), 64'h1);
        chk("bp_l_wb0", 64'(wb_o[0].rdval), 64'h32);

        // Flush with holdings 0 and 3 valid; FU1 input during flush is dropped
        drv(0, 1'b1, 6'd40, 32'h40); drv(3, 1'b1, 6'd43, 32'h43);
        settle(); tick();
        idle(); flush_i = 1'b1; drv(1, 1'b1, 6'd41, 32'h41); settle();
        chk("fl_n_bp_valid", 64'(bypass_valid_o), 64'h0);
        chk("fl_n_ready", 64'(fu_out_ready_o), 64'h0);
        tick(); flush_i = 1'b0; idle(); settle();
        chk("fl_o_wb_valid", 64'(wb_valid_o), 64'h0);
        chk("fl_o_bp_valid", 64'(bypass_valid_o), 64'h0);
        chk("fl_o_ready", 64'(fu_out_ready_o), 64'hF);
        tick();
        chk("fl_p_wb_valid", 64'(wb_valid_o), 64'h0);
        chk("fl_p_stat", 64'(stat_conflict_o), es(1));

        // Reset with two pending results
        drv(1, 1'b1, 6'd51, 32'h51); drv(2, 1'b1, 6'd52, 32'h52);
        settle(); tick();
        idle(); rst = 1'b1; settle();
        chk("rs_r_ready", 64'(fu_out_ready_o), 64'h0);
        chk("rs_r_bp_valid", 64'(bypass_valid_o), 64'h0);
        tick();
        chk("rs_s_wb_valid", 64'(wb_valid_o), 64'h0);
        chk("rs_s_ready", 64'(fu_out_ready_o), 64'h0);
        chk("rs_s_stat", 64'(stat_conflict_o), 64'h0);
        rst = 1'b0; settle();
        chk("rs_t_ready", 64'(fu_out_ready_o), 64'hF);
        chk("rs_t_bp_valid", 64'(bypass_valid_o), 64'h0);
        // rr_ptr back at 0: FUs 1,2,3 pending -> grants 1,2 first
        drv(1, 1'b1, 6'd61, 32'h61); drv(2, 1'b1, 6'd62, 32'h62); drv(3, 1'b1, 6'd63, 32'h63);
        settle(); tick(); idle(); settle();
        chk("rs_v_bp_valid", 64'(bypass_valid_o), 64'h3);
        chk("rs_v_bp0", 64'(bypass_o[0].prd), 64'd61);
        chk("rs_v_bp1", 64'(bypass_o[1].prd), 64'd62);
        chk("rs_v_ready", 64'(fu_out_ready_o), 64'h7);
        tick();
        chk("rs_w_bp_valid", 64'(bypass_valid_o), 64'h1);
        chk("rs_w_bp0", 64'(bypass_o[0].prd), 64'd63);
        chk("rs_w_wb1", 64'(wb_o[1].prd), 64'd62);
        chk("rs_w_stat", 64'(stat_conflict_o), es(1));
        tick();
        chk("rs_x_wb0", 64'(wb_o[0].prd), 64'd63);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Param NR_FU, default C::NR_FU (4), number of functional-unit result requesters.
REQ-002 Param NR_WB_PORTS, default C::NR_WB_PORTS (2), number of PRF/scoreboard writeback ports.
REQ-003 clk  input  1  sole clock, all state on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fu_out_i  input  fu_output_t[NR_FU]  FU results (pc, id, prd, rdval).
REQ-006 fu_out_valid_i  input  NR_FU  per-FU result valid.
REQ-007 fu_out_ready_o  output  NR_FU  per-FU accept; transfer when valid&&ready.
REQ-008 flush_i  input  1  drop all buffered and in-flight results.
REQ-009 bypass_o  output  fu_output_t[NR_WB_PORTS]  same-cycle winners, for issue-stage operand bypass.
REQ-010 bypass_valid_o  output  wb_bitvector_t  per-port bypass valid.
REQ-011 wb_o  output  fu_output_t[NR_WB_PORTS]  registered winners, drive PRF and scoreboard writes.
REQ-012 wb_valid_o  output  wb_bitvector_t  per-port writeback valid.
REQ-013 stat_conflict_o  output  32  cycles with at least one pending result not granted (see REQ-030).

Function
REQ-014 One single-entry holding register per FU; FU accepted result SHALL be written there on transfer.
REQ-015 fu_out_ready_o[f] SHALL be 1 iff holding[f] empty or holding[f] granted this cycle, and flush_i=0.
REQ-016 Candidates: valid holding entries only; no same-cycle input-to-grant path.
REQ-017 Each cycle, SHALL grant up to NR_WB_PORTS candidates, scanning FU indices rr_ptr, rr_ptr+1, ... mod NR_FU; k-th winner drives port k; unused ports invalid.
REQ-018 Winners SHALL appear on bypass_o/bypass_valid_o combinationally in the grant cycle.
REQ-019 Winners SHALL appear on wb_o/wb_valid_o exactly one cycle after grant (latency: accept -> bypass 1 cycle, -> wb 2 cycles).
REQ-020 Granted holding entry SHALL be cleared unless refilled by a same-cycle transfer (back-to-back throughput 1/cycle/FU).
REQ-021 rr_ptr SHALL become (index of last winner + 1) mod NR_FU when any grant occurs, else unchanged.
REQ-022 Any pending entry SHALL be granted within ceil(NR_FU/NR_WB_PORTS) cycles.
REQ-023 Candidates <= NR_WB_PORTS: all granted same cycle, no stall.
REQ-024 flush_i=1: all holding entries cleared and wb_valid_o=0 next cycle; bypass_valid_o=0 this cycle; inputs that cycle dropped; rr_ptr unchanged.
REQ-025 Two winners with equal prd is a protocol error; SHALL be flagged by assertion, not resolved.

Reset
REQ-026 rst SHALL clear all holding valids, wb_valid_o, rr_ptr=0, stat_conflict_o=0 on next clk edge.
REQ-027 While rst=1: fu_out_ready_o=0, bypass_valid_o=0; rst mid-operation discards buffered results.
REQ-028 wb_o and holding data fields SHALL not be reset (don't-care when invalid).

Configuration
REQ-029 Macro WB_ARBITER_STATS_EN selects statistics.
REQ-030 Defined: stat_conflict_o increments by 1 per cycle with ungranted valid holding entry and no flush, saturating at 2^32-1.
REQ-031 Undefined: counter not instantiated, stat_conflict_o tied 0; all other behaviour identical.

Structure
REQ-032 fu_output_t, wb_bitvector_t, NR_FU, NR_WB_PORTS SHALL live in package C; no new local typedefs for port types.
REQ-033 Rotating first-N picker SHALL be sub-module wb_rr_picker (req vector, start ptr in; NR_WB_PORTS one-hot grants, last index out).
REQ-034 wb_arbiter SHALL contain holding registers, output pipeline register, rr_ptr, stats.

Verification (NR_FU=4, NR_WB_PORTS=2)
REQ-035 FU0 valid prd=5 rdval=0xAA at cycle 0 -> bypass port0 prd=5 cycle 1, wb_o port0 prd=5 0xAA cycle 2.
REQ-036 All 4 FUs valid continuously, rr_ptr=0 -> grants {0,1},{2,3},{0,1}; each FU served every 2 cycles; stat_conflict_o +1 per cycle (STATS_EN).
REQ-037 FU2 valid, holding full and ungranted -> fu_out_ready_o[2]=0; after grant, ready=1 same cycle, new result accepted.
REQ-038 flush_i with holdings 0,3 valid -> bypass_valid_o=0 that cycle, wb_valid_o=0 next, holdings empty; no writeback of prd from 0 or 3.
REQ-039 rst asserted with 2 pending results -> next cycle wb_valid_o=0, ready=0 while rst, rr_ptr=0, counter=0.
REQ-040 STATS_EN undefined, REQ-036 stimulus -> stat_conflict_o stays 0, grant sequence unchanged.
